fetch_arb: RTL

- Shares the single line-fetch engine between the read controller and the write controller.
- Each controller raises a fetch request carrying cmd, tag, line address and the victim (pre) address. The arbiter picks one requester round-robin and forwards its request to the engine.
- It holds that ownership until the engine reports done, then routes the grant and done pulses back to the owning controller.
- Only one fetch is outstanding at any time.

---
 rtl/fetch_arb_if.sv | 61 ++++++
 rtl/fetch_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_arb_if.sv
// Fetch-request bus shared by the read/write controllers, the line-fetch engine and the arbiter.
interface fetch_arb_if #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned list_depth = 4
);
    localparam int unsigned TW = (list_depth > 1) ? $clog2(list_depth) : 1;

    // Read controller side
    logic                  rd_fetch_req;
    logic [1:0]            rd_fetch_cmd;
    logic [TW-1:0]         rd_fetch_tag;
    logic [addr_width-1:0] rd_fetch_addr;
    logic [addr_width-1:0] rd_fetch_addr_pre;
    logic                  rd_fetch_gnt;
    logic                  rd_fetch_done;

    // Write controller side
    logic                  wr_fetch_req;
    logic [1:0]            wr_fetch_cmd;
    logic [TW-1:0]         wr_fetch_tag;
    logic [addr_width-1:0] wr_fetch_addr;
    logic [addr_width-1:0] wr_fetch_addr_pre;
    logic                  wr_fetch_gnt;
    logic                  wr_fetch_done;

    // Fetch engine side
    logic                  eng_req;
    logic [1:0]            eng_cmd;
    logic [TW-1:0]         eng_tag;
    logic [addr_width-1:0] eng_addr;
    logic [addr_width-1:0] eng_addr_pre;
    logic                  eng_gnt;
    logic                  eng_done;

    // Status
    logic                  arb_busy;
    logic                  err_timeout;
    logic                  err_spurious;

    // Arbiter view
    modport slave (
        input  rd_fetch_req, rd_fetch_cmd, rd_fetch_tag, rd_fetch_addr, rd_fetch_addr_pre,
        output rd_fetch_gnt, rd_fetch_done,
        input  wr_fetch_req, wr_fetch_cmd, wr_fetch_tag, wr_fetch_addr, wr_fetch_addr_pre,
        output wr_fetch_gnt, wr_fetch_done,
        output eng_req, eng_cmd, eng_tag, eng_addr, eng_addr_pre,
        input  eng_gnt, eng_done,
        output arb_busy, err_timeout, err_spurious
    );

    // Requester/engine view
    modport master (
        output rd_fetch_req, rd_fetch_cmd, rd_fetch_tag, rd_fetch_addr, rd_fetch_addr_pre,
        input  rd_fetch_gnt, rd_fetch_done,
        output wr_fetch_req, wr_fetch_cmd, wr_fetch_tag, wr_fetch_addr, wr_fetch_addr_pre,
        input  wr_fetch_gnt, wr_fetch_done,
        input  eng_req, eng_cmd, eng_tag, eng_addr, eng_addr_pre,
        output eng_gnt, eng_done,
        input  arb_busy, err_timeout, err_spurious
    );
endinterface

// File: rtl/fetch_arb.sv
// Round-robin arbiter sharing one line-fetch engine between the read and write controllers.
module fetch_arb #(
    parameter int unsigned addr_width     = 32,
    parameter int unsigned list_depth     = 4,
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic      clk,
    input  logic      rst,
    fetch_arb_if.slave bus
);
    localparam int unsigned TW = (list_depth > 1) ? $clog2(list_depth) : 1;
    localparam int unsigned CW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_e;

    state_e          state_q;
    owner_e          owner_q;
    owner_e          last_q;
    owner_e          winner_c;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            tmo_hit_c;
    logic            err_timeout_q;
    logic            err_spurious_q;

    logic                  eng_req_c;
    logic [1:0]            eng_cmd_c;
    logic [TW-1:0]         eng_tag_c;
    logic [addr_width-1:0] eng_addr_c;
    logic [addr_width-1:0] eng_addr_pre_c;
    logic                  rd_gnt_c;
    logic                  wr_gnt_c;
    logic                  rd_done_c;
    logic                  wr_done_c;

    // Pick the winner: a lone requester wins, on a tie the one not served last wins.
    always_comb begin
        winner_c = OWN_RD;
        if (bus.rd_fetch_req && bus.wr_fetch_req) begin
            winner_c = (last_q == OWN_RD) ? OWN_WR : OWN_RD;
        end else if (bus.wr_fetch_req) begin
            winner_c = OWN_WR;
        end
    end

    // Saturating BUSY-cycle count and the point at which it reaches the timeout.
    always_comb begin
        cnt_d     = cnt_q;
        tmo_hit_c = 1'b0;
        if (timeout_cycles != 0) begin
            if (cnt_q != CW'(timeout_cycles)) begin
                cnt_d = cnt_q + CW'(1);
            end
            tmo_hit_c = (cnt_d == CW'(timeout_cycles));
        end
    end

    // Arbitration FSM with ownership, round-robin history, timeout counter and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_RD;
            last_q         <= OWN_WR;
            cnt_q          <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            if (bus.eng_done && (state_q != ST_BUSY)) begin
                err_spurious_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.rd_fetch_req || bus.wr_fetch_req) begin
                        owner_q <= winner_c;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.eng_gnt) begin
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_d;
                    if (bus.eng_done) begin
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else if (tmo_hit_c) begin
                        err_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Forward the owner's live request to the engine and route grant/done pulses back.
    always_comb begin
        eng_req_c      = 1'b0;
        eng_cmd_c      = '0;
        eng_tag_c      = '0;
        eng_addr_c     = '0;
        eng_addr_pre_c = '0;
        rd_gnt_c       = 1'b0;
        wr_gnt_c       = 1'b0;
        rd_done_c      = 1'b0;
        wr_done_c      = 1'b0;
        case (state_q)
            ST_REQ: begin
                eng_req_c = 1'b1;
                if (owner_q == OWN_RD) begin
                    eng_cmd_c      = bus.rd_fetch_cmd;
                    eng_tag_c      = bus.rd_fetch_tag;
                    eng_addr_c     = bus.rd_fetch_addr;
                    eng_addr_pre_c = bus.rd_fetch_addr_pre;
                    rd_gnt_c       = bus.eng_gnt;
                end else begin
                    eng_cmd_c      = bus.wr_fetch_cmd;
                    eng_tag_c      = bus.wr_fetch_tag;
                    eng_addr_c     = bus.wr_fetch_addr;
                    eng_addr_pre_c = bus.wr_fetch_addr_pre;
                    wr_gnt_c       = bus.eng_gnt;
                end
            end
            ST_BUSY: begin
                rd_done_c = bus.eng_done && (owner_q == OWN_RD);
                wr_done_c = bus.eng_done && (owner_q == OWN_WR);
            end
            default: begin
            end
        endcase
    end

    assign bus.eng_req       = eng_req_c;
    assign bus.eng_cmd       = eng_cmd_c;
    assign bus.eng_tag       = eng_tag_c;
    assign bus.eng_addr      = eng_addr_c;
    assign bus.eng_addr_pre  = eng_addr_pre_c;
    assign bus.rd_fetch_gnt  = rd_gnt_c;
    assign bus.wr_fetch_gnt  = wr_gnt_c;
    assign bus.rd_fetch_done = rd_done_c;
    assign bus.wr_fetch_done = wr_done_c;
    assign bus.arb_busy      = (state_q != ST_IDLE);
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_spurious  = err_spurious_q;

endmodule
